// File: rtl/field_narrow_unit.sv
// Two-stage narrowing unit: checks whether a signed 32-bit value fits the field
// pos..31 and emits the truncated or saturated field, plus a sticky overflow count.
module field_narrow_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      a,
  input  logic [0:4]       pos,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      y,
  output logic             ovl,
  output logic [0:CNT_W-1] ovl_cnt,
  input  logic             cnt_clr
);

  logic        s1_valid;
  logic [0:31] s1_a;
  logic [0:4]  s1_pos;
  logic        s1_sat;
  logic        s1_fit;
  logic        s1_sign;

  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic        fit_in;
  logic [0:31] y_next;

  // S2 can take new data when it is empty or its beat leaves this cycle.
  assign s2_adv    = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Fits iff the sign bit and every bit above the field agree.
  always_comb begin
    fit_in = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if (i <= int'(pos) && a[i] != a[0]) fit_in = 1'b0;
    end
  end

  always_comb begin
    y_next = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(s1_pos))         y_next[i] = 1'b0;
      else if (s1_fit || !s1_sat)   y_next[i] = s1_a[i];
      else if (i == int'(s1_pos))   y_next[i] = s1_sign;
      else                          y_next[i] = !s1_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_pos   <= '0;
      s1_sat   <= 1'b0;
      s1_fit   <= 1'b0;
      s1_sign  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_pos   <= pos;
      s1_sat   <= sat;
      s1_fit   <= fit_in;
      s1_sign  <= a[0];
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovl       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y   <= y_next;
        ovl <= !s1_fit;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovl_cnt <= '0;
    end else if (out_fire && ovl && ovl_cnt != {CNT_W{1'b1}}) begin
      ovl_cnt <= ovl_cnt + CNT_W'(1);
    end
  end

endmodule
